fetch_ctrl: RTL and testbench

- Sequences instruction fetch for the pipelined MIPS core over a variable-latency instruction memory with a req/ack handshake.
- Owns the PC register.
- Applies branch/jump redirects from later stages, discarding any stale in-flight response.
- Presents one registered instruction per transfer to the decode stage under a valid/ready handshake, which lets decode stall fetch.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_out_reg.sv | 36 +++
 rtl/fetch_ctrl.sv | 133 +++++++++++++
 tb/tb_fetch_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Width of the saturating timeout counter; TIMEOUT_CYC must fit in it.
  localparam int TMO_W = 16;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_out_reg.sv
// Valid/ready output register toward decode, with a wrong-path flush.
module fetch_out_reg (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        load,
  input  logic        ready,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_pcplus4,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pcplus4
);

  // Flush beats a refill, a refill beats a plain transfer that empties the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid   <= 1'b0;
      instr   <= 32'd0;
      pc      <= 32'd0;
      pcplus4 <= 32'd0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= fetch_instr;
      pc      <= fetch_pc;
      pcplus4 <= fetch_pcplus4;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, drives the imem req/ack
// handshake, applies redirects and feeds decode through fetch_out_reg.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcplus4,
  output logic        imem_err
);

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_MAX   = '1;
  localparam logic [TMO_W-1:0] TMO_ONE   = TMO_W'(1);

  fetch_state_e     state;
  logic [31:0]      pc;
  logic [31:0]      saved_pc;
  logic             pending;
  logic [TMO_W-1:0] tmo_cnt;
  logic             slot_free;
  logic             accept;
  logic             load;

  assign slot_free = !if_valid || if_ready;
  assign accept    = imem_req && imem_ack;
  assign load      = accept && (state == RUN) && !redirect_valid;

  // The address is always the PC: during DRAIN the PC still holds the stale
  // request address and the redirect target waits in saved_pc.
  assign imem_addr = pc;

  // Request while the output slot can take a word, and never drop a request
  // that the memory has not yet acknowledged.
  always_comb begin
    imem_req = 1'b0;
    case (state)
      RUN:     imem_req = slot_free || pending;
      DRAIN:   imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // Control FSM and PC update; a redirect outranks every other event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      saved_pc <= RESET_PC;
      pending  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= RUN;
          pending <= 1'b0;
          if (redirect_valid) pc <= redirect_pc;
        end
        RUN: begin
          pending <= imem_req && !imem_ack && !redirect_valid;
          if (redirect_valid) begin
            if (imem_req && !imem_ack) begin
              saved_pc <= redirect_pc;
              state    <= DRAIN;
            end else begin
              pc <= redirect_pc;
            end
          end else if (accept) begin
            pc <= next_pc(pc);
          end
        end
        DRAIN: begin
          pending <= 1'b0;
          if (imem_ack) begin
            pc    <= redirect_valid ? redirect_pc : saved_pc;
            state <= RUN;
          end else if (redirect_valid) begin
            saved_pc <= redirect_pc;
          end
        end
        default: begin
          state   <= IDLE;
          pending <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of unanswered request cycles and the sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt  <= '0;
      imem_err <= 1'b0;
    end else begin
      if (accept) begin
        tmo_cnt <= '0;
      end else if (imem_req && (tmo_cnt != TMO_MAX)) begin
        tmo_cnt <= tmo_cnt + TMO_ONE;
      end
      if ((TIMEOUT_CYC != 0) && imem_req && !imem_ack && ((tmo_cnt + TMO_ONE) >= TMO_LIMIT)) begin
        imem_err <= 1'b1;
      end
    end
  end

  fetch_out_reg u_out_reg (
    .clk           (clk),
    .reset         (reset),
    .flush         (redirect_valid),
    .load          (load),
    .ready         (if_ready),
    .fetch_instr   (imem_rdata),
    .fetch_pc      (pc),
    .fetch_pcplus4 (next_pc(pc)),
    .valid         (if_valid),
    .instr         (if_instr),
    .pc            (if_pc),
    .pcplus4       (if_pcplus4)
  );

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// phase scored against an instruction-stream model and a memory model.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC    = 32'h0000_0000;
  localparam int          TIMEOUT_CYC = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;
  logic        imem_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Memory model state
  bit          busy = 1'b0;
  int          wait_cnt = 0;
  int          lat = 0;
  int          lat_force = 0;
  logic [31:0] req_addr = 32'd0;

  // Architectural model: next PC decode should see, timeout streak, error flag
  logic [31:0] exp_pc = RESET_PC;
  int          tmo = 0;
  bit          exp_err = 1'b0;
  int          deliveries = 0;

  // Values seen just before the most recent active edge
  logic        s_req, s_ack, s_valid, s_rdy, s_redir;
  logic [31:0] s_addr, s_pc, s_instr, s_p4, s_rpc;

  fetch_ctrl #(
    .RESET_PC    (RESET_PC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pcplus4     (if_pcplus4),
    .imem_err       (imem_err)
  );

  // Free-running clock, period 10
  always #5 clk = ~clk;

  // Instruction memory contents as a fixed hash of the address
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hold reset for two cycles and restart both models
  task automatic doReset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    imem_ack = 1'b0;
    busy = 1'b0;
    tmo = 0;
    exp_err = 1'b0;
    exp_pc = RESET_PC;
    lat_force = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock cycle: drive decode/redirect inputs at the falling edge, answer
  // the memory, sample pre-edge values, then score the edge against the models.
  task automatic applyStimulus(input logic rdy, input logic redir, input logic [31:0] rpc);
    if_ready = rdy;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_ack = 1'b0;
    #1;
    if (busy) checkOutput("req_held", 32'(imem_req), 32'd1);
    if (imem_req) begin
      if (!busy) begin
        busy = 1'b1;
        wait_cnt = 0;
        lat = (lat_force >= 0) ? lat_force : $urandom_range(0, 3);
        req_addr = imem_addr;
      end else begin
        checkOutput("addr_stable", imem_addr, req_addr);
      end
      imem_ack = (wait_cnt == lat);
      imem_rdata = memWord(imem_addr);
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_ack = imem_ack;
    s_valid = if_valid; s_pc = if_pc; s_instr = if_instr; s_p4 = if_pcplus4;
    s_rdy = if_ready; s_redir = redirect_valid; s_rpc = redirect_pc;
    @(posedge clk);
    #1;
    if (s_req && s_ack) busy = 1'b0;
    else if (s_req) wait_cnt++;
    if (s_req && s_ack) tmo = 0;
    else if (s_req) tmo++;
    if (tmo >= TIMEOUT_CYC) exp_err = 1'b1;
    if (s_redir) begin
      exp_pc = s_rpc;
      checkOutput("flush", 32'(if_valid), 32'd0);
    end else if (s_valid && s_rdy) begin
      checkOutput("deliver_pc", s_pc, exp_pc);
      checkOutput("deliver_instr", s_instr, memWord(exp_pc));
      checkOutput("deliver_pcplus4", s_p4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      deliveries++;
    end
    checkOutput("err", 32'(imem_err), 32'(exp_err));
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] held_pc;
    logic [31:0] rpc;
    int reqs, acks, valids, start_del;

    // Reset values
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_valid", 32'(if_valid), 32'd0);
    checkOutput("rst_instr", if_instr, 32'd0);
    checkOutput("rst_pc", if_pc, 32'd0);
    checkOutput("rst_pcplus4", if_pcplus4, 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_err", 32'(imem_err), 32'd0);
    reset = 1'b0;

    // Zero-latency memory: one fetch per cycle after the single IDLE cycle
    lat_force = 0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t1_idle_req", 32'(s_req), 32'd0);
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("t1_req", 32'(s_req), 32'd1);
      checkOutput("t1_addr", s_addr, 32'(4 * (i - 1)));
      checkOutput("t1_valid", 32'(if_valid), 32'd1);
      checkOutput("t1_pc", if_pc, 32'(4 * (i - 1)));
      checkOutput("t1_pcplus4", if_pcplus4, 32'(4 * i));
    end

    // Three-cycle memory latency
    lat_force = 2;
    reqs = 0; acks = 0; valids = 0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      reqs += int'(s_req);
      acks += int'(s_req && s_ack);
      valids += int'(s_valid);
    end
    checkOutput("t2_req_cycles", 32'(reqs), 32'd12);
    checkOutput("t2_acks", 32'(acks), 32'd4);
    checkOutput("t2_valid_pulses", 32'(valids), 32'd4);

    // Decode stall holds the output and suppresses requests
    lat_force = 0;
    checkOutput("t3_pre_valid", 32'(if_valid), 32'd1);
    held_pc = if_pc;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 32'd0);
      checkOutput("t3_req_low", 32'(s_req), 32'd0);
      checkOutput("t3_hold_valid", 32'(if_valid), 32'd1);
      checkOutput("t3_hold_pc", if_pc, held_pc);
      checkOutput("t3_hold_instr", if_instr, memWord(held_pc));
    end
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t3_req_resume", 32'(s_req), 32'd1);
    checkOutput("t3_addr_resume", s_addr, held_pc + 32'd4);

    // Redirect while the request to 0x8 is outstanding
    doReset();
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    lat_force = 2;
    applyStimulus(1'b1, 1'b1, 32'h100);
    checkOutput("t4_addr_redir", s_addr, 32'h8);
    checkOutput("t4_ack_redir", 32'(s_ack), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t4_drain_req", 32'(s_req), 32'd1);
    checkOutput("t4_drain_addr", s_addr, 32'h8);
    checkOutput("t4_drain_valid", 32'(s_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t4_drain_ack", 32'(s_ack), 32'd1);
    checkOutput("t4_valid_after", 32'(if_valid), 32'd0);
    lat_force = 0;
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t4_new_addr", s_addr, 32'h100);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 32'd0);

    // Redirect coinciding with an ack at 0x10
    applyStimulus(1'b1, 1'b1, 32'h10);
    applyStimulus(1'b1, 1'b1, 32'h40);
    checkOutput("t5_addr", s_addr, 32'h10);
    checkOutput("t5_ack", 32'(s_ack), 32'd1);
    checkOutput("t5_valid", 32'(if_valid), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t5_next_addr", s_addr, 32'h40);

    // Randomized traffic: decode stalls, random latency, random redirects
    lat_force = -1;
    start_del = deliveries;
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_03FC);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rpc);
    end
    checkOutput("rand_progress", 32'(deliveries - start_del > 100), 32'd1);

    // Timeout: let any open request finish, then starve the next one
    lat_force = 0;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 32'd0);
    lat_force = 9;
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b0, 32'd0);
      checkOutput("t6_err", 32'(imem_err), 32'(k >= 4));
    end
    checkOutput("t6_late_ack", 32'(s_ack), 32'd1);
    lat_force = 5;
    applyStimulus(1'b1, 1'b0, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'd0);
    checkOutput("t6_err_sticky", 32'(imem_err), 32'd1);
    checkOutput("t6_req_open", 32'(imem_req), 32'd1);

    // Asynchronous reset in the middle of a request
    #3;
    reset = 1'b1;
    #1;
    checkOutput("t6_rst_req", 32'(imem_req), 32'd0);
    checkOutput("t6_rst_err", 32'(imem_err), 32'd0);
    checkOutput("t6_rst_valid", 32'(if_valid), 32'd0);
    checkOutput("t6_rst_addr", imem_addr, RESET_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
